// File: rtl/trivium_byte_sequencer.sv
// Byte feeder/collector for the trivium lite core; define TRIV_SEQ_STATS_EN for a saturating delivered-byte counter.
// Pop-to-out_valid is 10 cycles; in_ready = !full; a result arriving while out_valid is stalled is dropped and flagged.

module trivium_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         empty,
   output logic         full_nxt
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: cnt_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign empty    = (cnt_q == '0);
   assign full_nxt = (cnt_d == (AW+1)'(DEPTH));
endmodule

module trivium_byte_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [7:0]  seed_i,
   input  logic        stop_i,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  core_data_o,
   output logic [7:0]  core_ctrl_o,
   input  logic [7:0]  core_result_i,
   output logic        busy_o,
   output logic        overflow_o,
   output logic [15:0] byte_cnt_o
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEED  = 3'd1,
      ST_RUN   = 3'd2,
      ST_STOP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] win_cnt_q, win_cnt_d;
   logic       hold_vld_q, hold_vld_d;
   logic       prev_vld_q, prev_vld_d;
   logic [7:0] core_data_q, core_data_d;
   logic [7:0] core_ctrl_q, core_ctrl_d;
   logic [7:0] out_dat_q, out_dat_d;
   logic       out_vld_q, out_vld_d;
   logic       ovf_q, ovf_d;
   logic       in_rdy_q, in_rdy_d;
   logic       busy_q, busy_d;

   logic       fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full_nxt;
   logic [7:0] fifo_head;

   assign fifo_push = in_valid && in_rdy_q;

   trivium_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (fifo_flush),
      .push     (fifo_push),
      .push_dat (in_data),
      .pop      (fifo_pop),
      .head_dat (fifo_head),
      .empty    (fifo_empty),
      .full_nxt (fifo_full_nxt)
   );

   always_comb begin
      state_d     = state_q;
      win_cnt_d   = win_cnt_q;
      hold_vld_d  = hold_vld_q;
      prev_vld_d  = prev_vld_q;
      core_data_d = core_data_q;
      core_ctrl_d = 8'h00;
      out_dat_d   = out_dat_q;
      out_vld_d   = out_vld_q;
      ovf_d       = ovf_q;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;

      if (out_vld_q && out_ready) out_vld_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i && seed_i != 8'h00 && seed_i != 8'hFF) begin
               state_d     = ST_SEED;
               core_ctrl_d = seed_i;
            end
         end
         ST_SEED: begin
            win_cnt_d = 3'd0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (stop_i) begin
               state_d     = ST_STOP;
               core_ctrl_d = 8'hFF;
            end else begin
               win_cnt_d = win_cnt_q + 3'd1;
               if (win_cnt_q == 3'd0) begin
                  prev_vld_d = hold_vld_q;
                  if (!fifo_empty) begin
                     fifo_pop    = 1'b1;
                     core_data_d = fifo_head;
                     hold_vld_d  = 1'b1;
                  end else begin
                     core_data_d = 8'h00;
                     hold_vld_d  = 1'b0;
                  end
               end
               // Core result from the previous window settled at the last win_cnt==7 edge.
               if (win_cnt_q == 3'd1 && prev_vld_q) begin
                  if (!out_vld_q || out_ready) begin
                     out_dat_d = core_result_i;
                     out_vld_d = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
         ST_STOP: begin
            fifo_flush  = 1'b1;
            hold_vld_d  = 1'b0;
            prev_vld_d  = 1'b0;
            win_cnt_d   = 3'd0;
            core_data_d = 8'h00;
            state_d     = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      in_rdy_d = !fifo_full_nxt;
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         win_cnt_q   <= 3'd0;
         hold_vld_q  <= 1'b0;
         prev_vld_q  <= 1'b0;
         core_data_q <= 8'h00;
         core_ctrl_q <= 8'h00;
         out_dat_q   <= 8'h00;
         out_vld_q   <= 1'b0;
         ovf_q       <= 1'b0;
         in_rdy_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         hold_vld_q  <= hold_vld_d;
         prev_vld_q  <= prev_vld_d;
         core_data_q <= core_data_d;
         core_ctrl_q <= core_ctrl_d;
         out_dat_q   <= out_dat_d;
         out_vld_q   <= out_vld_d;
         ovf_q       <= ovf_d;
         in_rdy_q    <= in_rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready    = in_rdy_q;
   assign out_data    = out_dat_q;
   assign out_valid   = out_vld_q;
   assign core_data_o = core_data_q;
   assign core_ctrl_o = core_ctrl_q;
   assign busy_o      = busy_q;
   assign overflow_o  = ovf_q;

`ifdef TRIV_SEQ_STATS_EN
   logic [15:0] byte_cnt_q, byte_cnt_d;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (out_vld_q && out_ready && byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) byte_cnt_q <= 16'h0000;
      else        byte_cnt_q <= byte_cnt_d;
   end

   assign byte_cnt_o = byte_cnt_q;
`else
   assign byte_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_trivium_byte_sequencer.sv
// Directed-sequence bench with random data/seeds against a behavioural core and keystream model.
module tb_trivium_byte_sequencer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [7:0]  seed_i = 8'h00;
   logic        stop_i = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  core_data_o;
   logic [7:0]  core_ctrl_o;
   logic [7:0]  core_result_i;
   logic        busy_o;
   logic        overflow_o;
   logic [15:0] byte_cnt_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   trivium_byte_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .seed_i        (seed_i),
      .stop_i        (stop_i),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .core_data_o   (core_data_o),
      .core_ctrl_o   (core_ctrl_o),
      .core_result_i (core_result_i),
      .busy_o        (busy_o),
      .overflow_o    (overflow_o),
      .byte_cnt_o    (byte_cnt_o)
   );

   // Keystream byte k for a given seed: any fixed invertible-ish scramble will do.
   function automatic logic [7:0] ks(input logic [7:0] s, input int k);
      logic [7:0] x;
      x = s;
      for (int i = 0; i <= k; i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
      return x ^ 8'(k * 37);
   endfunction

   // Core model: seeds on a non-zero control byte, resets on 0xFF,
   // and emits data ^ keystream at every eighth step after seeding.
   logic       core_run = 1'b0;
   logic [2:0] core_step = 3'd0;
   logic [7:0] core_seed = 8'h00;
   int         core_k = 0;
   logic [7:0] core_res = 8'h00;
   assign core_result_i = core_res;

   always @(posedge clk) begin
      if (core_ctrl_o == 8'hFF) begin
         core_run  <= 1'b0;
         core_step <= 3'd0;
      end else if (core_ctrl_o != 8'h00) begin
         core_run  <= 1'b1;
         core_seed <= core_ctrl_o;
         core_step <= 3'd0;
         core_k    <= 0;
      end else if (core_run) begin
         core_step <= core_step + 3'd1;
         if (core_step == 3'd7) begin
            core_res <= core_data_o ^ ks(core_seed, core_k);
            core_k   <= core_k + 1;
         end
      end
   end

   // Expected delivered-byte count: handshakes seen since the last reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) hs_cnt = 0;
      else if (out_valid && out_ready) hs_cnt = hs_cnt + 1;
   end

   function automatic int exp_cnt();
`ifdef TRIV_SEQ_STATS_EN
      return hs_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push_idle(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   // Leaves the bench at RUN cycle 0 (first cycle with win_cnt==0).
   task automatic start_run(input logic [7:0] s);
      start_i = 1'b1;
      seed_i  = s;
      tick();
      start_i = 1'b0;
      chk("seed_ctrl", 32'(core_ctrl_o), 32'(s));
      chk("seed_busy", 32'(busy_o), 32'd1);
      tick();
      cyc = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_core_data"}, 32'(core_data_o), 32'd0);
      chk({tag, "_core_ctrl"}, 32'(core_ctrl_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
      chk({tag, "_byte_cnt"}, 32'(byte_cnt_o), 32'd0);
   endtask

   initial begin
      logic [7:0] b [DEPTH+1];
      logic [7:0] c [3];
      logic [7:0] s;

      // Power-on reset.
      repeat (2) @(negedge clk);
      chk_all_zero("por");
      rst_n = 1'b1;
      tick();
      chk("por_in_ready", 32'(in_ready), 32'd1);
      chk("por_busy", 32'(busy_o), 32'd0);

      // Single zero byte with seed 0x3C: ciphertext is the raw keystream byte.
      push_idle(8'h00);
      start_run(8'h3C);
      to_cyc(9);
      chk("single_early", 32'(out_valid), 32'd0);
      to_cyc(10);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'(ks(8'h3C, 0)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_clear", 32'(out_valid), 32'd0);

      // Reset in the middle of RUN with a byte sitting in the FIFO.
      push_idle(8'hAA);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("midrst_busy", 32'(busy_o), 32'd0);

      // FIFO full in IDLE: DEPTH+1 attempts, the last one refused.
      for (int i = 0; i <= DEPTH; i++) b[i] = 8'($urandom);
      in_valid = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         in_data = b[i];
         chk($sformatf("full_rdy%0d", i), 32'(in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
         tick();
      end
      in_valid = 1'b0;
      chk("full_cnt", 32'(byte_cnt_o), 32'(exp_cnt()));

      // Streaming: preloaded byte i pops in window i, so it meets keystream byte i.
      s = 8'($urandom_range(1, 254));
      start_run(s);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         to_cyc(10 + 8 * i);
         chk($sformatf("stream_vld%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("stream_dat%0d", i), 32'(out_data), 32'(b[i] ^ ks(s, i)));
         tick();
         chk($sformatf("stream_clr%0d", i), 32'(out_valid), 32'd0);
         chk($sformatf("stream_core%0d", i), 32'(core_data_o), (i < DEPTH - 1) ? 32'(b[i+1]) : 32'd0);
      end
      to_cyc(10 + 8 * DEPTH);
      chk("stream_no5th", 32'(out_valid), 32'd0);
      chk("stream_cnt", 32'(byte_cnt_o), 32'(exp_cnt()));
      to_cyc(44);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("stop1_ctrl", 32'(core_ctrl_o), 32'hFF);
      tick();
      chk("stop1_drain", 32'(core_ctrl_o), 32'h00);
      chk("stop1_busy_drain", 32'(busy_o), 32'd1);
      tick();
      chk("stop1_idle", 32'(busy_o), 32'd0);
      out_ready = 1'b0;

      // Backpressure: first result held, next two dropped, then stop at win_cnt==4.
      for (int i = 0; i < 3; i++) begin
         c[i] = 8'($urandom);
         push_idle(c[i]);
      end
      s = 8'($urandom_range(1, 254));
      start_run(s);
      to_cyc(4);
      chk("bp_core_data", 32'(core_data_o), 32'(c[0]));
      to_cyc(10);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_dat", 32'(out_data), 32'(c[0] ^ ks(s, 0)));
      chk("bp_no_ovf", 32'(overflow_o), 32'd0);
      to_cyc(18);
      chk("bp_ovf", 32'(overflow_o), 32'd1);
      chk("bp_held", 32'(out_data), 32'(c[0] ^ ks(s, 0)));
      to_cyc(24);
      in_valid = 1'b1;
      repeat (DEPTH) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      chk("bp_fifo_full", 32'(in_ready), 32'd0);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("stop2_ctrl", 32'(core_ctrl_o), 32'hFF);
      tick();
      chk("stop2_drain", 32'(core_ctrl_o), 32'h00);
      chk("stop2_flushed", 32'(in_ready), 32'd1);
      tick();
      chk("stop2_idle", 32'(busy_o), 32'd0);
      chk("stop2_pend_vld", 32'(out_valid), 32'd1);
      chk("stop2_pend_dat", 32'(out_data), 32'(c[0] ^ ks(s, 0)));
      chk("stop2_ovf", 32'(overflow_o), 32'd1);

      // Invalid seeds and stop in IDLE are ignored.
      start_i = 1'b1;
      seed_i  = 8'hFF;
      tick();
      chk("bad_ff_busy", 32'(busy_o), 32'd0);
      chk("bad_ff_ctrl", 32'(core_ctrl_o), 32'h00);
      seed_i = 8'h00;
      tick();
      start_i = 1'b0;
      chk("bad_00_busy", 32'(busy_o), 32'd0);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("idle_stop_busy", 32'(busy_o), 32'd0);

      // Retire the pending byte.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("drain_clr", 32'(out_valid), 32'd0);
      chk("drain_cnt", 32'(byte_cnt_o), 32'(exp_cnt()));
      chk("drain_ovf_sticky", 32'(overflow_o), 32'd1);

      // Flushed FIFO accepts exactly DEPTH bytes again.
      in_valid = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         in_data = 8'($urandom);
         chk($sformatf("refill_rdy%0d", i), 32'(in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
         tick();
      end
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
